// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide (radix-2 shift-add, restoring divide).
// Optional macro MULDIV_FAST_SPECIAL_EN: divide-by-zero / signed overflow finish straight from IDLE.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;       // {hi, lo}: product, or {remainder, quotient}
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept, is_div, sign_a, sign_b, b_zero, neg_new;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic              last, rem_ge, hi_sel;
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [XLEN-1:0]   rem_new, fixed_sel;
    logic [2*XLEN-1:0] step, fixed;

    always_comb begin : decode
        accept = (state_q == S_IDLE) && valid_i && !flush_i;
        is_div = funct3_i[2];
        sign_a = op_a_i[XLEN-1] && (funct3_i == 3'b001 || funct3_i == 3'b010 ||
                                    funct3_i == 3'b100 || funct3_i == 3'b110);
        sign_b = op_b_i[XLEN-1] && (funct3_i == 3'b001 || funct3_i == 3'b100 ||
                                    funct3_i == 3'b110);
        mag_a  = sign_a ? -op_a_i : op_a_i;
        mag_b  = sign_b ? -op_b_i : op_b_i;
        b_zero = (op_b_i == '0);
        // A zero divisor yields an all-ones quotient that must not be negated.
        if (!is_div)
            neg_new = sign_a ^ sign_b;
        else if (funct3_i[1])
            neg_new = sign_a;
        else
            neg_new = (sign_a ^ sign_b) && !b_zero;
    end

`ifdef MULDIV_FAST_SPECIAL_EN
    logic ovf;
    always_comb begin : fast_special
        ovf     = !funct3_i[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
        special = is_div && (b_zero || ovf);
        if (b_zero)
            special_res = funct3_i[1] ? op_a_i : '1;
        else
            special_res = funct3_i[1] ? '0 : op_a_i;
    end
`else
    assign special     = 1'b0;
    assign special_res = '0;
`endif

    always_comb begin : step_calc
        last    = (cnt_q == CNT_LAST);
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_ge  = (rem_sh >= {1'b0, opnd_q});
        rem_new = rem_ge ? XLEN'(rem_sh - {1'b0, opnd_q}) : rem_sh[XLEN-1:0];
        step    = op_q[2] ? {rem_new, acc_q[XLEN-2:0], rem_ge}
                          : {mul_sum, acc_q[XLEN-1:1]};
        fixed   = step;
        if (neg_q) begin
            if (!op_q[2])
                fixed = -step;
            else if (op_q[1])
                fixed[2*XLEN-1:XLEN] = -step[2*XLEN-1:XLEN];
            else
                fixed[XLEN-1:0] = -step[XLEN-1:0];
        end
        // MUL/DIV/DIVU take the low half; MULH*, REM, REMU the high half.
        hi_sel    = op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00);
        fixed_sel = hi_sel ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
    end

    always_comb begin : datapath
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (accept) begin
            op_d   = funct3_i;
            neg_d  = neg_new;
            cnt_d  = '0;
            opnd_d = is_div ? mag_b : mag_a;
            acc_d  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            if (special)
                result_d = special_res;
        end else if (state_q == S_CALC) begin
            if (flush_i) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = last ? fixed : step;
                if (last)
                    result_d = fixed_sel;
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_i)
                    state_d = S_IDLE;
                else if (last)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        ready_o  = (state_q == S_IDLE);
        busy_o   = (state_q != S_IDLE);
        done_o   = (state_q == S_DONE);
        result_o = result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin : data_reg
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against an arithmetic model,
// and hand-written flush / mid-operation reset sequences. Honours MULDIV_FAST_SPECIAL_EN for latency.
`timescale 1ns/1ps
module tb_muldiv_unit;
    localparam int XLEN = 32;
`ifdef MULDIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [2:0]      funct3_i = '0;
    logic [XLEN-1:0] op_a_i = '0;
    logic [XLEN-1:0] op_b_i = '0;
    logic            ready_o, busy_o, done_o;
    logic [XLEN-1:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic plus the RISC-V corner-case rules.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic int exp_lat(input bit special);
        return (FAST && special) ? 1 : XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issues one request at a negedge and follows it to its done pulse; returns on a negedge.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
        int lat;
        bit seen;
        for (int i = 0; i < 64 && !ready_o; i++) @(negedge clk);
        valid_i  = 1'b1;
        funct3_i = f;
        op_a_i   = a;
        op_b_i   = b;
        @(posedge clk);
        @(negedge clk);
        valid_i  = 1'b0;
        funct3_i = 3'($urandom);
        op_a_i   = 32'($urandom);
        op_b_i   = 32'($urandom);
        check({name, " busy after accept"}, 64'(busy_o), 64'd1);
        lat  = 1;
        seen = 1'b0;
        while (lat <= 100) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({name, " done seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({name, " result"}, 64'(result_o), 64'(exp));
            check({name, " latency"}, 64'(lat), 64'(lat_exp));
            $display("op %-14s f=%0d a=%08h b=%08h result=%08h latency=%0d", name, f, a, b, result_o, lat);
            @(negedge clk);
            check({name, " done one cycle"}, {62'd0, done_o, ready_o}, 64'd1);
            check({name, " result held"}, 64'(result_o), 64'(exp));
        end
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{"MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{"MULH min*min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
        vecs[2]  = '{"MULHU 2^31^2",    3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
        vecs[3]  = '{"MULHSU -1*max",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{"DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{"REM -7%2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{"DIVU 100/7",      3'd5, 32'd100,        32'd7,         32'd14,        1'b0};
        vecs[7]  = '{"REMU 100%7",      3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
        vecs[8]  = '{"DIVU 5/0",        3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{"REM 5%0",         3'd6, 32'd5,          32'd0,         32'd5,         1'b1};
        vecs[10] = '{"DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[11] = '{"REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
        vecs[12] = '{"DIV -7/0",        3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[13] = '{"REM -7%0",        3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1};
        vecs[14] = '{"MULH -1*-1",      3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[15] = '{"MULHU max*max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", 64'(ready_o), 64'd1);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset result", 64'(result_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, exp_lat(vecs[i].special));

        for (int n = 0; n < 150; n++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom);
            a = pick();
            b = pick();
            run_op($sformatf("rand%0d", n), f, a, b, model(f, a, b), exp_lat(is_special(f, a, b)));
        end

        // Flush in CALC cycle 10: no pulse, immediate IDLE, previous result kept
        run_op("DIVU seed", 3'd5, 32'd100, 32'd7, 32'd14, XLEN + 1);
        valid_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'h1234; op_b_i = 32'h5678;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("flush pre done c%0d", c), 64'(done_o), 64'd0);
            @(negedge clk);
        end
        check("flush busy before", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush ready", 64'(ready_o), 64'd1);
        check("flush busy", 64'(busy_o), 64'd0);
        check("flush done", 64'(done_o), 64'd0);
        check("flush result kept", 64'(result_o), 64'd14);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check($sformatf("flush no done c%0d", c), 64'(done_o), 64'd0);
        end
        run_op("MUL 6*7", 3'd0, 32'd6, 32'd7, 32'd42, XLEN + 1);

        // Reset in CALC cycle 5, then flush-gated acceptance after release
        valid_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd1000; op_b_i = 32'd3;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst ready", 64'(ready_o), 64'd1);
        check("midrst busy", 64'(busy_o), 64'd0);
        check("midrst done", 64'(done_o), 64'd0);
        check("midrst result", 64'(result_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd9; op_b_i = 32'd9;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("flush gate ready c%0d", c), 64'(ready_o), 64'd1);
            check($sformatf("flush gate busy c%0d", c), 64'(busy_o), 64'd0);
        end
        flush_i = 1'b0;
        run_op("MUL 9*9", 3'd0, 32'd9, 32'd9, 32'd81, XLEN + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
